book_update_sequencer: RTL and testbench
========================================

// Module: book_update_sequencer
// PURPOSE
//  Sequences decoded ITCH order messages (add/delete/execute) from the MoldUDP/ITCH parser into order-book updates.
//  Owns the order-reference table (external 1-cycle-latency RAM) and issues one price-level update per message to the book.
//  Sits between the ITCH parser output and the price-level book inside ethernet_to_book_top, on the 250 MHz core clock.
// PARAMETERS
//  ADDR_W  10  order-table address width (2**ADDR_W direct-mapped slots)
// PORTS
//  clkIn          in   1    core clock; all logic single clock domain
//  rstIn          in   1    synchronous, active-high reset
//  msgValidIn     in   1    parsed ITCH message valid
//  msgReadyOut    out  1    sequencer accepts message this cycle
//  msgTypeIn      in   8    ASCII type: 'A' add, 'D' delete, 'E' executed
//  refNumIn       in   64   order reference number
//  buySellIn      in   1    side (add only), BUY=1
//  sharesIn       in   32   add shares / executed shares
//  priceIn        in   32   price, $0.0001 units (add only)
//  tblAddrOut     out  ADDR_W  table slot address
//  tblRdEnOut     out  1    table read strobe; data valid on tblRdDataIn next cycle
//  tblRdDataIn    in   orderEntryType  {valid, refNum, buySell, shares, price}
//  tblWrEnOut     out  1    table write strobe
//  tblWrDataOut   out  orderEntryType  entry to write
//  bookValidOut   out  1    book update valid
//  bookReadyIn    in   1    book accepts update
//  bookOpOut      out  1    BOOK_ADD=0 / BOOK_SUB=1
//  bookSideOut    out  1    side of level
//  bookPriceOut   out  32   level price
//  bookSharesOut  out  32   shares to add/subtract
//  errPulseOut    out  1    1-cycle pulse: dropped message
//  dropCntOut     out  16   saturating count of dropped messages
// BEHAVIOUR
//  - Reset: state IDLE; msgReadyOut=1 after reset; all strobes/valids 0; data outs 0; dropCntOut 0.
//  - One message in flight; msgReadyOut=1 only in IDLE. Accept = msgValidIn & msgReadyOut (cycle N).
//  - Slot = refNum[ADDR_W-1:0] ^ refNum[2*ADDR_W-1:ADDR_W]; match = rd.valid & (rd.refNum == captured refNum).
//  - FSM: IDLE -> LOOKUP (N+1: tblRdEnOut=1, tblAddrOut=slot) -> RESOLVE (N+2: tblRdDataIn sampled)
//    -> BOOK (N+3: tblWrEnOut 1-cycle pulse if write needed; bookValidOut=1 held with stable data until bookReadyIn) -> IDLE.
//  - Min throughput 1 message / 4 cycles with bookReadyIn=1; bookReadyIn low holds BOOK, outputs frozen.
//  - Add: slot valid (any ref) -> collision drop. Else write {1,ref,side,shares,price}; book ADD side/price/shares.
//  - Delete: match -> write entry with valid=0; book SUB entry side/price/entry.shares. No match -> drop.
//  - Execute: match -> if exec >= entry.shares: clear entry, book SUB entry.shares;
//    else write entry.shares-exec (32-bit, no underflow possible), book SUB exec. No match -> drop.
//  - Unknown msgType: accepted, RESOLVE -> IDLE, no table write, no book output, not counted as drop.
//  - Drop: RESOLVE -> IDLE, errPulseOut=1 at N+3, dropCntOut+1 saturating at 16'hFFFF, no write, no book output.
//  - rstIn mid-message: aborts immediately, pending table write/book update discarded; table contents untouched.
//  - Shares of 0 on add are legal and stored as-is.
// CONFIGURATION
//  - BOOK_SEQ_STATS_EN defined: extra out ports addCntOut, delCntOut, execCntOut (32b, wrap) count completed book updates per type.
//  - Not defined: ports still present, tied to 0; no counter flops.
// STRUCTURE
//  - book_pkg: ADD_MSG_TYPE/DELETE_MSG_TYPE/EXECUTED_MSG_TYPE, BUY/SELL, orderEntryType struct, bookOpType enum, seqStateType enum.
//  - Sub-module order_ref_hash (refNum -> slot); FSM, capture regs, counters in top.
// TESTING
//  - Add ref DEFB1673DEFB1673 BUY 0x45 @0x0022FEFC -> write valid entry; book ADD BUY 0x0022FEFC 0x45 at N+3.
//  - Add ref DEF12373DEFDE89C, then delete same -> entry cleared; book SUB BUY 0x0022FEFC 0x45.
//  - Add ref ABCD167ABCDB1005 shares 0x555, exec 0x100 -> entry shares 0x455; book SUB 0x100.
//  - Exec ABCD167ABCDB1005 shares 0xABCD7684 on 0x555 entry -> entry cleared; book SUB 0x555.
//  - Delete unknown ref 0x1234 -> errPulseOut 1 cycle, dropCntOut=1, no bookValidOut/tblWrEnOut.
//  - bookReadyIn low 5 cycles then rstIn mid-BOOK -> outputs stable while stalled; after reset all outputs 0, msgReadyOut=1.

Source files
------------

// File: rtl/book_pkg.sv
// ---------------------------------------------------------------------------
// book_pkg
// Shared definitions for the ITCH-to-order-book sequencer: the ASCII message
// type codes it understands, the side encoding, the layout of one slot in the
// order-reference table, the book operation encoding and the sequencer FSM
// states.
// ---------------------------------------------------------------------------
package book_pkg;

   localparam logic [7:0] ADD_MSG_TYPE      = 8'h41;
   localparam logic [7:0] DELETE_MSG_TYPE   = 8'h44;
   localparam logic [7:0] EXECUTED_MSG_TYPE = 8'h45;

   localparam logic BUY  = 1'b1;
   localparam logic SELL = 1'b0;

   typedef struct packed {
      logic        valid;
      logic [63:0] refNum;
      logic        buySell;
      logic [31:0] shares;
      logic [31:0] price;
   } orderEntryType;

   typedef enum logic {
      BOOK_ADD = 1'b0,
      BOOK_SUB = 1'b1
   } bookOpType;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOOKUP  = 2'd1,
      RESOLVE = 2'd2,
      BOOK    = 2'd3
   } seqStateType;

endpackage

// File: rtl/order_ref_hash.sv
// ---------------------------------------------------------------------------
// order_ref_hash
// Folds a 64-bit ITCH order reference number into a direct-mapped slot index
// of the order-reference table by XOR-ing its two lowest ADDR_W-bit fields.
//
// Ports
//   ref_num  in   64      order reference number
//   slot     out  ADDR_W  table slot index
// ---------------------------------------------------------------------------
module order_ref_hash #(
   parameter int ADDR_W = 10
) (
   input  logic [63:0]       ref_num,
   output logic [ADDR_W-1:0] slot
);

   assign slot = ref_num[ADDR_W-1:0] ^ ref_num[2*ADDR_W-1:ADDR_W];

endmodule

// File: rtl/book_update_sequencer.sv
// ---------------------------------------------------------------------------
// book_update_sequencer
// Turns decoded ITCH add / delete / executed messages into price-level
// updates for the order book. One message is in flight at a time: it is
// looked up in the external order-reference table (1-cycle read latency),
// resolved against the stored entry, the table is updated and a single
// book update is offered until the book accepts it.
//
// Optional feature: define BOOK_SEQ_STATS_EN to enable the per-type counters
// of completed book updates. Without it the counter ports are tied to 0.
//
// Ports
//   clkIn, rstIn            core clock, synchronous active-high reset
//   msgValidIn/ReadyOut     parsed message handshake
//   msgTypeIn, refNumIn, buySellIn, sharesIn, priceIn   message fields
//   tblAddrOut, tblRdEnOut, tblRdDataIn                 table read port
//   tblWrEnOut, tblWrDataOut                            table write port
//   bookValidOut/ReadyIn    book update handshake
//   bookOpOut, bookSideOut, bookPriceOut, bookSharesOut  book update fields
//   errPulseOut, dropCntOut dropped-message pulse and saturating count
//   addCntOut, delCntOut, execCntOut  completed updates per message type
// ---------------------------------------------------------------------------
module book_update_sequencer
   import book_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clkIn,
   input  logic              rstIn,
   input  logic              msgValidIn,
   output logic              msgReadyOut,
   input  logic [7:0]        msgTypeIn,
   input  logic [63:0]       refNumIn,
   input  logic              buySellIn,
   input  logic [31:0]       sharesIn,
   input  logic [31:0]       priceIn,
   output logic [ADDR_W-1:0] tblAddrOut,
   output logic              tblRdEnOut,
   input  orderEntryType     tblRdDataIn,
   output logic              tblWrEnOut,
   output orderEntryType     tblWrDataOut,
   output logic              bookValidOut,
   input  logic              bookReadyIn,
   output logic              bookOpOut,
   output logic              bookSideOut,
   output logic [31:0]       bookPriceOut,
   output logic [31:0]       bookSharesOut,
   output logic              errPulseOut,
   output logic [15:0]       dropCntOut,
   output logic [31:0]       addCntOut,
   output logic [31:0]       delCntOut,
   output logic [31:0]       execCntOut
);

   seqStateType   state_q, state_d;
   logic [7:0]    msg_type_q, msg_type_d;
   logic [63:0]   ref_q, ref_d;
   logic          side_q, side_d;
   logic [31:0]   shares_q, shares_d;
   logic [31:0]   price_q, price_d;
   logic          wr_en_q, wr_en_d;
   orderEntryType wr_data_q, wr_data_d;
   bookOpType     book_op_q, book_op_d;
   logic          book_side_q, book_side_d;
   logic [31:0]   book_price_q, book_price_d;
   logic [31:0]   book_shares_q, book_shares_d;
   logic          err_q, err_d;
   logic [15:0]   drop_cnt_q, drop_cnt_d;

   logic [ADDR_W-1:0] slot;
   logic              ref_match;
   logic              drop;

   order_ref_hash #(.ADDR_W(ADDR_W)) u_hash (
      .ref_num (ref_q),
      .slot    (slot)
   );

   assign ref_match = tblRdDataIn.valid && (tblRdDataIn.refNum == ref_q);

   // Next-state and datapath. The message is captured on accept; in RESOLVE
   // the table entry read in LOOKUP is available and decides the table write
   // and the book update, both registered so they appear together in BOOK.
   // Adds drop on any occupied slot (no chaining), delete/execute drop when
   // the slot holds a different reference or nothing at all.
   always_comb begin
      state_d       = state_q;
      msg_type_d    = msg_type_q;
      ref_d         = ref_q;
      side_d        = side_q;
      shares_d      = shares_q;
      price_d       = price_q;
      wr_en_d       = 1'b0;
      wr_data_d     = wr_data_q;
      book_op_d     = book_op_q;
      book_side_d   = book_side_q;
      book_price_d  = book_price_q;
      book_shares_d = book_shares_q;
      err_d         = 1'b0;
      drop_cnt_d    = drop_cnt_q;
      drop          = 1'b0;

      case (state_q)
         IDLE: begin
            if (msgValidIn) begin
               msg_type_d = msgTypeIn;
               ref_d      = refNumIn;
               side_d     = buySellIn;
               shares_d   = sharesIn;
               price_d    = priceIn;
               state_d    = LOOKUP;
            end
         end
         LOOKUP: begin
            state_d = RESOLVE;
         end
         RESOLVE: begin
            state_d = IDLE;
            case (msg_type_q)
               ADD_MSG_TYPE: begin
                  if (tblRdDataIn.valid) begin
                     drop = 1'b1;
                  end else begin
                     wr_en_d       = 1'b1;
                     wr_data_d     = '{valid: 1'b1, refNum: ref_q, buySell: side_q,
                                       shares: shares_q, price: price_q};
                     book_op_d     = BOOK_ADD;
                     book_side_d   = side_q;
                     book_price_d  = price_q;
                     book_shares_d = shares_q;
                     state_d       = BOOK;
                  end
               end
               DELETE_MSG_TYPE: begin
                  if (ref_match) begin
                     wr_en_d         = 1'b1;
                     wr_data_d       = tblRdDataIn;
                     wr_data_d.valid = 1'b0;
                     book_op_d       = BOOK_SUB;
                     book_side_d     = tblRdDataIn.buySell;
                     book_price_d    = tblRdDataIn.price;
                     book_shares_d   = tblRdDataIn.shares;
                     state_d         = BOOK;
                  end else begin
                     drop = 1'b1;
                  end
               end
               EXECUTED_MSG_TYPE: begin
                  if (ref_match) begin
                     wr_en_d      = 1'b1;
                     wr_data_d    = tblRdDataIn;
                     book_op_d    = BOOK_SUB;
                     book_side_d  = tblRdDataIn.buySell;
                     book_price_d = tblRdDataIn.price;
                     if (shares_q >= tblRdDataIn.shares) begin
                        wr_data_d.valid = 1'b0;
                        book_shares_d   = tblRdDataIn.shares;
                     end else begin
                        wr_data_d.shares = tblRdDataIn.shares - shares_q;
                        book_shares_d    = shares_q;
                     end
                     state_d = BOOK;
                  end else begin
                     drop = 1'b1;
                  end
               end
               default: begin
               end
            endcase
            if (drop) begin
               err_d = 1'b1;
               if (drop_cnt_q != 16'hFFFF) begin
                  drop_cnt_d = drop_cnt_q + 16'd1;
               end
            end
         end
         BOOK: begin
            if (bookReadyIn) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and capture registers. Reset abandons any message in flight,
   // including a pending write pulse, so the table is never touched by it.
   always_ff @(posedge clkIn) begin
      if (rstIn) begin
         state_q       <= IDLE;
         msg_type_q    <= '0;
         ref_q         <= '0;
         side_q        <= 1'b0;
         shares_q      <= '0;
         price_q       <= '0;
         wr_en_q       <= 1'b0;
         wr_data_q     <= '0;
         book_op_q     <= BOOK_ADD;
         book_side_q   <= 1'b0;
         book_price_q  <= '0;
         book_shares_q <= '0;
         err_q         <= 1'b0;
         drop_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         msg_type_q    <= msg_type_d;
         ref_q         <= ref_d;
         side_q        <= side_d;
         shares_q      <= shares_d;
         price_q       <= price_d;
         wr_en_q       <= wr_en_d;
         wr_data_q     <= wr_data_d;
         book_op_q     <= book_op_d;
         book_side_q   <= book_side_d;
         book_price_q  <= book_price_d;
         book_shares_q <= book_shares_d;
         err_q         <= err_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

`ifdef BOOK_SEQ_STATS_EN
   logic [31:0] add_cnt_q, add_cnt_d;
   logic [31:0] del_cnt_q, del_cnt_d;
   logic [31:0] exec_cnt_q, exec_cnt_d;

   // An update counts as completed on the book handshake, attributed to the
   // type of the message that produced it.
   always_comb begin
      add_cnt_d  = add_cnt_q;
      del_cnt_d  = del_cnt_q;
      exec_cnt_d = exec_cnt_q;
      if ((state_q == BOOK) && bookReadyIn) begin
         case (msg_type_q)
            ADD_MSG_TYPE:      add_cnt_d  = add_cnt_q + 32'd1;
            DELETE_MSG_TYPE:   del_cnt_d  = del_cnt_q + 32'd1;
            EXECUTED_MSG_TYPE: exec_cnt_d = exec_cnt_q + 32'd1;
            default: begin
            end
         endcase
      end
   end

   // Wrapping statistics counters.
   always_ff @(posedge clkIn) begin
      if (rstIn) begin
         add_cnt_q  <= '0;
         del_cnt_q  <= '0;
         exec_cnt_q <= '0;
      end else begin
         add_cnt_q  <= add_cnt_d;
         del_cnt_q  <= del_cnt_d;
         exec_cnt_q <= exec_cnt_d;
      end
   end

   assign addCntOut  = add_cnt_q;
   assign delCntOut  = del_cnt_q;
   assign execCntOut = exec_cnt_q;
`else
   assign addCntOut  = '0;
   assign delCntOut  = '0;
   assign execCntOut = '0;
`endif

   assign msgReadyOut   = (state_q == IDLE);
   assign tblRdEnOut    = (state_q == LOOKUP);
   assign tblAddrOut    = (state_q == IDLE) ? '0 : slot;
   assign tblWrEnOut    = wr_en_q;
   assign tblWrDataOut  = wr_data_q;
   assign bookValidOut  = (state_q == BOOK);
   assign bookOpOut     = book_op_q;
   assign bookSideOut   = book_side_q;
   assign bookPriceOut  = book_price_q;
   assign bookSharesOut = book_shares_q;
   assign errPulseOut   = err_q;
   assign dropCntOut    = drop_cnt_q;

endmodule

// File: tb/tb_book_update_sequencer.sv
// ---------------------------------------------------------------------------
// tb_book_update_sequencer
// Directed bench for book_update_sequencer. Models the external order table
// as a 1-cycle-latency RAM and checks lookups, table writes, book updates,
// drops, throughput, stall behaviour and reset abort with hand-computed values.
// ---------------------------------------------------------------------------
module tb_book_update_sequencer;
   import book_pkg::*;

   logic          clkIn = 1'b0;
   logic          rstIn = 1'b1;
   logic          msgValidIn = 1'b0;
   logic          msgReadyOut;
   logic [7:0]    msgTypeIn = '0;
   logic [63:0]   refNumIn = '0;
   logic          buySellIn = 1'b0;
   logic [31:0]   sharesIn = '0;
   logic [31:0]   priceIn = '0;
   logic [9:0]    tblAddrOut;
   logic          tblRdEnOut;
   orderEntryType tblRdDataIn = '0;
   logic          tblWrEnOut;
   orderEntryType tblWrDataOut;
   logic          bookValidOut;
   logic          bookReadyIn = 1'b1;
   logic          bookOpOut;
   logic          bookSideOut;
   logic [31:0]   bookPriceOut;
   logic [31:0]   bookSharesOut;
   logic          errPulseOut;
   logic [15:0]   dropCntOut;
   logic [31:0]   addCntOut;
   logic [31:0]   delCntOut;
   logic [31:0]   execCntOut;

   int asserts = 0;
   int failures = 0;

   orderEntryType ram [0:1023] = '{default: '0};
   logic          ramClr = 1'b0;
   logic [9:0]    ramClrAddr = '0;

   int wrPulses = 0;
   int bookHs = 0;
   int cyc = 0;
   int lastHsCyc = 0;
   int hsGap = 0;

   always #5 clkIn = ~clkIn;

   book_update_sequencer #(.ADDR_W(10)) dut (
      .clkIn         (clkIn),
      .rstIn         (rstIn),
      .msgValidIn    (msgValidIn),
      .msgReadyOut   (msgReadyOut),
      .msgTypeIn     (msgTypeIn),
      .refNumIn      (refNumIn),
      .buySellIn     (buySellIn),
      .sharesIn      (sharesIn),
      .priceIn       (priceIn),
      .tblAddrOut    (tblAddrOut),
      .tblRdEnOut    (tblRdEnOut),
      .tblRdDataIn   (tblRdDataIn),
      .tblWrEnOut    (tblWrEnOut),
      .tblWrDataOut  (tblWrDataOut),
      .bookValidOut  (bookValidOut),
      .bookReadyIn   (bookReadyIn),
      .bookOpOut     (bookOpOut),
      .bookSideOut   (bookSideOut),
      .bookPriceOut  (bookPriceOut),
      .bookSharesOut (bookSharesOut),
      .errPulseOut   (errPulseOut),
      .dropCntOut    (dropCntOut),
      .addCntOut     (addCntOut),
      .delCntOut     (delCntOut),
      .execCntOut    (execCntOut)
   );

   // External order table: read data appears the cycle after the strobe.
   always @(posedge clkIn) begin
      if (tblRdEnOut) tblRdDataIn <= ram[tblAddrOut];
      if (ramClr) ram[ramClrAddr] <= '0;
      else if (tblWrEnOut) ram[tblAddrOut] <= tblWrDataOut;
   end

   // Activity monitors for write pulses and accepted book updates.
   always @(posedge clkIn) begin
      cyc <= cyc + 1;
      if (tblWrEnOut) wrPulses <= wrPulses + 1;
      if (bookValidOut && bookReadyIn) begin
         bookHs    <= bookHs + 1;
         hsGap     <= cyc - lastHsCyc;
         lastHsCyc <= cyc;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "[TB] watchdog");
   end

   task automatic step();
      @(posedge clkIn);
      #1;
   endtask

   task automatic sendMsg(input logic [7:0] t, input logic [63:0] r, input logic s,
                          input logic [31:0] sh, input logic [31:0] p);
      int waitCnt;
      waitCnt = 0;
      while (msgReadyOut !== 1'b1 && waitCnt < 20) begin
         step();
         waitCnt++;
      end
      if (msgReadyOut !== 1'b1) begin
         asserts++;
         failures++;
         $display("[TB] FAIL ready_timeout: msgReadyOut=%b after %0d cycles, expected 1", msgReadyOut, waitCnt);
      end
      msgValidIn = 1'b1;
      msgTypeIn  = t;
      refNumIn   = r;
      buySellIn  = s;
      sharesIn   = sh;
      priceIn    = p;
      step();
      msgValidIn = 1'b0;
   endtask

   task automatic runMsg(input logic [7:0] t, input logic [63:0] r, input logic s,
                         input logic [31:0] sh, input logic [31:0] p);
      sendMsg(t, r, s, sh, p);
      step();
      step();
      step();
   endtask

   task automatic test_reset();
      rstIn = 1'b1;
      step();
      step();
      rstIn = 1'b0;
      asserts++;
      if (msgReadyOut !== 1'b1 || tblRdEnOut !== 1'b0 || tblWrEnOut !== 1'b0 || bookValidOut !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_ctrl: ready=%b rdEn=%b wrEn=%b bookValid=%b, expected 1/0/0/0",
                  msgReadyOut, tblRdEnOut, tblWrEnOut, bookValidOut);
      end
      asserts++;
      if (errPulseOut !== 1'b0 || dropCntOut !== 16'h0 || tblAddrOut !== 10'h0) begin
         failures++;
         $display("[TB] FAIL reset_err: err=%b drop=%h addr=%h, expected 0/0000/000", errPulseOut, dropCntOut, tblAddrOut);
      end
      asserts++;
      if (bookPriceOut !== 32'h0 || bookSharesOut !== 32'h0 || tblWrDataOut !== 130'h0) begin
         failures++;
         $display("[TB] FAIL reset_data: price=%h shares=%h wrData=%h, expected all 0", bookPriceOut, bookSharesOut, tblWrDataOut);
      end
   endtask

   task automatic test_add();
      orderEntryType exp;
      exp = '{valid: 1'b1, refNum: 64'hDEFB1673DEFB1673, buySell: 1'b1, shares: 32'h45, price: 32'h0022FEFC};
      sendMsg(ADD_MSG_TYPE, 64'hDEFB1673DEFB1673, BUY, 32'h45, 32'h0022FEFC);
      asserts++;
      if (tblRdEnOut !== 1'b1 || tblAddrOut !== 10'h0B6 || msgReadyOut !== 1'b0) begin
         failures++;
         $display("[TB] FAIL add_lookup: rdEn=%b addr=%h ready=%b, expected 1/0b6/0", tblRdEnOut, tblAddrOut, msgReadyOut);
      end
      step();
      asserts++;
      if (bookValidOut !== 1'b0 || tblWrEnOut !== 1'b0 || tblRdEnOut !== 1'b0) begin
         failures++;
         $display("[TB] FAIL add_resolve: bookValid=%b wrEn=%b rdEn=%b, expected 0/0/0", bookValidOut, tblWrEnOut, tblRdEnOut);
      end
      step();
      asserts++;
      if (tblWrEnOut !== 1'b1 || tblWrDataOut !== exp || tblAddrOut !== 10'h0B6) begin
         failures++;
         $display("[TB] FAIL add_write: wrEn=%b data=%h addr=%h, expected 1/%h/0b6", tblWrEnOut, tblWrDataOut, tblAddrOut, exp);
      end
      asserts++;
      if (bookValidOut !== 1'b1 || bookOpOut !== 1'b0 || bookSideOut !== 1'b1 ||
          bookPriceOut !== 32'h0022FEFC || bookSharesOut !== 32'h45) begin
         failures++;
         $display("[TB] FAIL add_book: valid=%b op=%b side=%b price=%h shares=%h, expected 1/0/1/0022fefc/00000045",
                  bookValidOut, bookOpOut, bookSideOut, bookPriceOut, bookSharesOut);
      end
      step();
      asserts++;
      if (msgReadyOut !== 1'b1 || bookValidOut !== 1'b0 || tblWrEnOut !== 1'b0 || ram[10'h0B6] !== exp) begin
         failures++;
         $display("[TB] FAIL add_done: ready=%b bookValid=%b wrEn=%b ram=%h, expected 1/0/0/%h",
                  msgReadyOut, bookValidOut, tblWrEnOut, ram[10'h0B6], exp);
      end
   endtask

   task automatic test_delete();
      runMsg(ADD_MSG_TYPE, 64'hDEF12373DEFDE89C, BUY, 32'h45, 32'h0022FEFC);
      asserts++;
      if (ram[10'h3E6].valid !== 1'b1 || ram[10'h3E6].refNum !== 64'hDEF12373DEFDE89C) begin
         failures++;
         $display("[TB] FAIL del_setup: valid=%b ref=%h, expected 1/def12373defde89c", ram[10'h3E6].valid, ram[10'h3E6].refNum);
      end
      sendMsg(DELETE_MSG_TYPE, 64'hDEF12373DEFDE89C, 1'b0, 32'h0, 32'h0);
      step();
      step();
      asserts++;
      if (bookValidOut !== 1'b1 || bookOpOut !== 1'b1 || bookSideOut !== 1'b1 ||
          bookPriceOut !== 32'h0022FEFC || bookSharesOut !== 32'h45) begin
         failures++;
         $display("[TB] FAIL del_book: valid=%b op=%b side=%b price=%h shares=%h, expected 1/1/1/0022fefc/00000045",
                  bookValidOut, bookOpOut, bookSideOut, bookPriceOut, bookSharesOut);
      end
      asserts++;
      if (tblWrEnOut !== 1'b1 || tblWrDataOut.valid !== 1'b0 || tblAddrOut !== 10'h3E6) begin
         failures++;
         $display("[TB] FAIL del_write: wrEn=%b valid=%b addr=%h, expected 1/0/3e6", tblWrEnOut, tblWrDataOut.valid, tblAddrOut);
      end
      step();
      asserts++;
      if (ram[10'h3E6].valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL del_cleared: ram valid=%b, expected 0", ram[10'h3E6].valid);
      end
   endtask

   task automatic test_exec_partial();
      runMsg(ADD_MSG_TYPE, 64'hABCD167ABCDB1005, SELL, 32'h555, 32'h00100000);
      sendMsg(EXECUTED_MSG_TYPE, 64'hABCD167ABCDB1005, 1'b0, 32'h100, 32'h0);
      asserts++;
      if (tblAddrOut !== 10'h2C1) begin
         failures++;
         $display("[TB] FAIL exp_lookup: addr=%h, expected 2c1", tblAddrOut);
      end
      step();
      step();
      asserts++;
      if (bookValidOut !== 1'b1 || bookOpOut !== 1'b1 || bookSideOut !== 1'b0 ||
          bookPriceOut !== 32'h00100000 || bookSharesOut !== 32'h100) begin
         failures++;
         $display("[TB] FAIL exp_book: valid=%b op=%b side=%b price=%h shares=%h, expected 1/1/0/00100000/00000100",
                  bookValidOut, bookOpOut, bookSideOut, bookPriceOut, bookSharesOut);
      end
      asserts++;
      if (tblWrEnOut !== 1'b1 || tblWrDataOut.valid !== 1'b1 || tblWrDataOut.shares !== 32'h455) begin
         failures++;
         $display("[TB] FAIL exp_write: wrEn=%b valid=%b shares=%h, expected 1/1/00000455",
                  tblWrEnOut, tblWrDataOut.valid, tblWrDataOut.shares);
      end
      step();
      asserts++;
      if (ram[10'h2C1].shares !== 32'h455 || ram[10'h2C1].valid !== 1'b1) begin
         failures++;
         $display("[TB] FAIL exp_entry: shares=%h valid=%b, expected 00000455/1", ram[10'h2C1].shares, ram[10'h2C1].valid);
      end
   endtask

   task automatic test_exec_full();
      ramClrAddr = 10'h2C1;
      ramClr = 1'b1;
      step();
      ramClr = 1'b0;
      runMsg(ADD_MSG_TYPE, 64'hABCD167ABCDB1005, SELL, 32'h555, 32'h00100000);
      sendMsg(EXECUTED_MSG_TYPE, 64'hABCD167ABCDB1005, 1'b0, 32'hABCD7684, 32'h0);
      step();
      step();
      asserts++;
      if (bookValidOut !== 1'b1 || bookOpOut !== 1'b1 || bookSharesOut !== 32'h555) begin
         failures++;
         $display("[TB] FAIL exf_book: valid=%b op=%b shares=%h, expected 1/1/00000555", bookValidOut, bookOpOut, bookSharesOut);
      end
      asserts++;
      if (tblWrEnOut !== 1'b1 || tblWrDataOut.valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL exf_write: wrEn=%b valid=%b, expected 1/0", tblWrEnOut, tblWrDataOut.valid);
      end
      step();
      asserts++;
      if (ram[10'h2C1].valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL exf_cleared: ram valid=%b, expected 0", ram[10'h2C1].valid);
      end
   endtask

   task automatic test_drop();
      int wr0;
      int hs0;
      wr0 = wrPulses;
      hs0 = bookHs;
      sendMsg(DELETE_MSG_TYPE, 64'h1234, 1'b0, 32'h0, 32'h0);
      step();
      asserts++;
      if (errPulseOut !== 1'b0 || dropCntOut !== 16'd0) begin
         failures++;
         $display("[TB] FAIL drop_early: err=%b drop=%0d, expected 0/0", errPulseOut, dropCntOut);
      end
      step();
      asserts++;
      if (errPulseOut !== 1'b1 || dropCntOut !== 16'd1 || bookValidOut !== 1'b0 || msgReadyOut !== 1'b1) begin
         failures++;
         $display("[TB] FAIL drop_pulse: err=%b drop=%0d bookValid=%b ready=%b, expected 1/1/0/1",
                  errPulseOut, dropCntOut, bookValidOut, msgReadyOut);
      end
      step();
      asserts++;
      if (errPulseOut !== 1'b0 || wrPulses !== wr0 || bookHs !== hs0) begin
         failures++;
         $display("[TB] FAIL drop_quiet: err=%b writes=%0d books=%0d, expected 0/%0d/%0d", errPulseOut, wrPulses, bookHs, wr0, hs0);
      end
   endtask

   task automatic test_collision();
      int wr0;
      wr0 = wrPulses;
      sendMsg(ADD_MSG_TYPE, 64'h00000000000000B6, BUY, 32'h10, 32'h20);
      asserts++;
      if (tblAddrOut !== 10'h0B6) begin
         failures++;
         $display("[TB] FAIL col_lookup: addr=%h, expected 0b6", tblAddrOut);
      end
      step();
      step();
      asserts++;
      if (errPulseOut !== 1'b1 || dropCntOut !== 16'd2 || bookValidOut !== 1'b0) begin
         failures++;
         $display("[TB] FAIL col_drop: err=%b drop=%0d bookValid=%b, expected 1/2/0", errPulseOut, dropCntOut, bookValidOut);
      end
      step();
      asserts++;
      if (wrPulses !== wr0 || ram[10'h0B6].refNum !== 64'hDEFB1673DEFB1673) begin
         failures++;
         $display("[TB] FAIL col_entry: writes=%0d ref=%h, expected %0d/defb1673defb1673", wrPulses, ram[10'h0B6].refNum, wr0);
      end
   endtask

   task automatic test_unknown();
      int wr0;
      int hs0;
      wr0 = wrPulses;
      hs0 = bookHs;
      sendMsg(8'h58, 64'hDEFB1673DEFB1673, BUY, 32'h1, 32'h1);
      step();
      step();
      asserts++;
      if (msgReadyOut !== 1'b1 || errPulseOut !== 1'b0 || bookValidOut !== 1'b0 || dropCntOut !== 16'd2) begin
         failures++;
         $display("[TB] FAIL unk_idle: ready=%b err=%b bookValid=%b drop=%0d, expected 1/0/0/2",
                  msgReadyOut, errPulseOut, bookValidOut, dropCntOut);
      end
      step();
      asserts++;
      if (wrPulses !== wr0 || bookHs !== hs0) begin
         failures++;
         $display("[TB] FAIL unk_quiet: writes=%0d books=%0d, expected %0d/%0d", wrPulses, bookHs, wr0, hs0);
      end
   endtask

   task automatic test_back_to_back();
      int c0;
      int hs0;
      c0 = cyc;
      hs0 = bookHs;
      sendMsg(ADD_MSG_TYPE, 64'h11, BUY, 32'h1, 32'h100);
      sendMsg(ADD_MSG_TYPE, 64'h22, SELL, 32'h2, 32'h200);
      sendMsg(ADD_MSG_TYPE, 64'h33, BUY, 32'h3, 32'h300);
      step();
      step();
      step();
      asserts++;
      if (cyc - c0 !== 12 || bookHs - hs0 !== 3 || msgReadyOut !== 1'b1) begin
         failures++;
         $display("[TB] FAIL b2b_rate: cycles=%0d updates=%0d ready=%b, expected 12/3/1", cyc - c0, bookHs - hs0, msgReadyOut);
      end
      asserts++;
      if (hsGap !== 4) begin
         failures++;
         $display("[TB] FAIL b2b_gap: gap=%0d, expected 4", hsGap);
      end
      asserts++;
      if (ram[10'h22].shares !== 32'h2 || ram[10'h22].buySell !== 1'b0 || ram[10'h33].price !== 32'h300) begin
         failures++;
         $display("[TB] FAIL b2b_entries: sh22=%h side22=%b pr33=%h, expected 2/0/300",
                  ram[10'h22].shares, ram[10'h22].buySell, ram[10'h33].price);
      end
   endtask

   task automatic test_stats();
      logic [31:0] expAdd;
      logic [31:0] expDel;
      logic [31:0] expExec;
`ifdef BOOK_SEQ_STATS_EN
      expAdd  = 32'd7;
      expDel  = 32'd1;
      expExec = 32'd2;
`else
      expAdd  = 32'd0;
      expDel  = 32'd0;
      expExec = 32'd0;
`endif
      asserts++;
      if (addCntOut !== expAdd || delCntOut !== expDel || execCntOut !== expExec) begin
         failures++;
         $display("[TB] FAIL stats: add=%0d del=%0d exec=%0d, expected %0d/%0d/%0d",
                  addCntOut, delCntOut, execCntOut, expAdd, expDel, expExec);
      end
   endtask

   task automatic test_stall_reset();
      bookReadyIn = 1'b0;
      sendMsg(ADD_MSG_TYPE, 64'h44, SELL, 32'h77, 32'h1000);
      step();
      step();
      asserts++;
      if (bookValidOut !== 1'b1 || tblWrEnOut !== 1'b1 || bookPriceOut !== 32'h1000 || bookSharesOut !== 32'h77) begin
         failures++;
         $display("[TB] FAIL stall_enter: valid=%b wrEn=%b price=%h shares=%h, expected 1/1/00001000/00000077",
                  bookValidOut, tblWrEnOut, bookPriceOut, bookSharesOut);
      end
      for (int i = 0; i < 5; i++) begin
         step();
         asserts++;
         if (bookValidOut !== 1'b1 || tblWrEnOut !== 1'b0 || bookOpOut !== 1'b0 || bookSideOut !== 1'b0 ||
             bookPriceOut !== 32'h1000 || bookSharesOut !== 32'h77 || msgReadyOut !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stall_hold[%0d]: valid=%b wrEn=%b op=%b side=%b price=%h shares=%h ready=%b, expected 1/0/0/0/1000/77/0",
                     i, bookValidOut, tblWrEnOut, bookOpOut, bookSideOut, bookPriceOut, bookSharesOut, msgReadyOut);
         end
      end
      rstIn = 1'b1;
      step();
      asserts++;
      if (bookValidOut !== 1'b0 || msgReadyOut !== 1'b1 || tblWrEnOut !== 1'b0 || tblRdEnOut !== 1'b0) begin
         failures++;
         $display("[TB] FAIL abort_ctrl: bookValid=%b ready=%b wrEn=%b rdEn=%b, expected 0/1/0/0",
                  bookValidOut, msgReadyOut, tblWrEnOut, tblRdEnOut);
      end
      asserts++;
      if (bookPriceOut !== 32'h0 || bookSharesOut !== 32'h0 || tblWrDataOut !== 130'h0 || dropCntOut !== 16'h0 || errPulseOut !== 1'b0) begin
         failures++;
         $display("[TB] FAIL abort_data: price=%h shares=%h wrData=%h drop=%h err=%b, expected all 0",
                  bookPriceOut, bookSharesOut, tblWrDataOut, dropCntOut, errPulseOut);
      end
      rstIn = 1'b0;
      bookReadyIn = 1'b1;
      step();
      asserts++;
      if (ram[10'h0B6].valid !== 1'b1 || ram[10'h0B6].refNum !== 64'hDEFB1673DEFB1673 || msgReadyOut !== 1'b1) begin
         failures++;
         $display("[TB] FAIL abort_table: valid=%b ref=%h ready=%b, expected 1/defb1673defb1673/1",
                  ram[10'h0B6].valid, ram[10'h0B6].refNum, msgReadyOut);
      end
   endtask

   // Scenario sequence; each task leaves the sequencer idle for the next.
   initial begin
      test_reset();
      test_add();
      test_delete();
      test_exec_partial();
      test_exec_full();
      test_drop();
      test_collision();
      test_unknown();
      test_back_to_back();
      test_stats();
      test_stall_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end

endmodule
